// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter between pipeline (P) and long-latency (L) writeback,
// with a pending-destination scoreboard for RAW/WAW issue stalls.
module rf_wb_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned NREG         = 32,
  parameter int unsigned AW           = 5,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            p_valid,
  output logic            p_ready,
  input  logic [AW-1:0]   p_rd,
  input  logic [XLEN-1:0] p_data,
  input  logic            l_valid,
  output logic            l_ready,
  input  logic [AW-1:0]   l_rd,
  input  logic [XLEN-1:0] l_data,
  input  logic            sb_set,
  input  logic [AW-1:0]   sb_rd,
  input  logic [AW-1:0]   chk_rs1,
  input  logic [AW-1:0]   chk_rs2,
  input  logic [AW-1:0]   chk_rd,
  output logic            hazard,
  output logic            sb_err,
  output logic            rf_we,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_wdata
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0]   starve_q, starve_d;
  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            out_is_l_q, out_is_l_d;
  logic [NREG-1:0] pending_q, pending_d;
  logic            sb_err_q, sb_err_d;

  logic force_l, p_xfer, l_xfer, sb_setv, sb_clr;

  assign force_l = (starve_q == CW'(STARVE_LIMIT));
  assign p_ready = !force_l;
  assign l_ready = force_l | !p_valid;
  assign p_xfer  = p_valid & p_ready;
  assign l_xfer  = l_valid & l_ready;

  // The committing L write frees its destination on the same edge the regfile writes.
  assign sb_clr  = rf_we_q & out_is_l_q;
  assign sb_setv = sb_set & (sb_rd != '0);

  always_comb begin
    starve_d   = starve_q;
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    out_is_l_d = out_is_l_q;
    pending_d  = pending_q;
    sb_err_d   = sb_err_q;

    if (l_xfer || !l_valid) begin
      starve_d = '0;
    end else if (!force_l) begin
      starve_d = starve_q + CW'(1);
    end

    if (p_xfer) begin
      rf_we_d    = (p_rd != '0);
      rf_rd_d    = p_rd;
      rf_wdata_d = p_data;
      out_is_l_d = 1'b0;
    end else if (l_xfer) begin
      rf_we_d    = (l_rd != '0);
      rf_rd_d    = l_rd;
      rf_wdata_d = l_data;
      out_is_l_d = 1'b1;
    end

    if (sb_clr) begin
      pending_d[rf_rd_q] = 1'b0;
    end
    if (sb_setv) begin
      if (pending_q[sb_rd] && !(sb_clr && (rf_rd_q == sb_rd))) begin
        sb_err_d = 1'b1;
      end
      pending_d[sb_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      out_is_l_q <= 1'b0;
      pending_q  <= '0;
      sb_err_q   <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      out_is_l_q <= out_is_l_d;
      pending_q  <= pending_d;
      sb_err_q   <= sb_err_d;
    end
  end

  assign hazard   = pending_q[chk_rs1] | pending_q[chk_rs2] | pending_q[chk_rd];
  assign sb_err   = sb_err_q;
  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus random traffic checked against a
// cycle-level behavioural model of the arbitration, output and scoreboard rules.
module tb_rf_wb_arbiter;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned LIMIT = 4;

  logic            clk = 1'b0;
  logic            resetn;
  logic            p_valid, p_ready, l_valid, l_ready;
  logic [AW-1:0]   p_rd, l_rd, sb_rd, chk_rs1, chk_rs2, chk_rd, rf_rd;
  logic [XLEN-1:0] p_data, l_data, rf_wdata;
  logic            sb_set, hazard, sb_err, rf_we;

  int checks = 0;
  int errors = 0;

  // Model state
  bit            m_we, m_is_l, m_err;
  bit [AW-1:0]   m_rd;
  bit [XLEN-1:0] m_wdata;
  bit            m_pend [NREG];
  int            m_starve;
  int            last_win; // 0 none, 1 P, 2 L

  rf_wb_arbiter #(
    .XLEN(XLEN), .NREG(NREG), .AW(AW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .resetn(resetn),
    .p_valid(p_valid), .p_ready(p_ready), .p_rd(p_rd), .p_data(p_data),
    .l_valid(l_valid), .l_ready(l_ready), .l_rd(l_rd), .l_data(l_data),
    .sb_set(sb_set), .sb_rd(sb_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .hazard(hazard), .sb_err(sb_err),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_we = 0; m_is_l = 0; m_err = 0; m_rd = '0; m_wdata = '0; m_starve = 0;
    foreach (m_pend[i]) m_pend[i] = 0;
  endtask

  function automatic bit model_hazard();
    return m_pend[chk_rs1] || m_pend[chk_rs2] || m_pend[chk_rd];
  endfunction

  task automatic idle();
    p_valid = 0; p_rd = '0; p_data = '0;
    l_valid = 0; l_rd = '0; l_data = '0;
    sb_set = 0; sb_rd = '0; chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
  endtask

  // One clock: check comb outputs, advance the model, clock, check registered outputs.
  task automatic step();
    bit forced, exp_pr, exp_lr, commit_l;
    bit [AW-1:0] commit_rd;
    #1;
    forced = (m_starve == LIMIT);
    exp_pr = !forced;
    exp_lr = forced || !p_valid;
    check("p_ready", p_ready, exp_pr);
    check("l_ready", l_ready, exp_lr);
    check("hazard", hazard, model_hazard());

    if (p_valid && exp_pr)      last_win = 1;
    else if (l_valid && exp_lr) last_win = 2;
    else                        last_win = 0;

    commit_l  = m_we && m_is_l;
    commit_rd = m_rd;
    if (commit_l) m_pend[commit_rd] = 0;
    if (sb_set && sb_rd != 0) begin
      if (m_pend[sb_rd]) m_err = 1;
      m_pend[sb_rd] = 1;
    end

    if (l_valid && last_win != 2) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
    else                          m_starve = 0;

    m_we = 0;
    if (last_win == 1) begin
      m_we = (p_rd != 0); m_rd = p_rd; m_wdata = p_data; m_is_l = 0;
    end else if (last_win == 2) begin
      m_we = (l_rd != 0); m_rd = l_rd; m_wdata = l_data; m_is_l = 1;
    end

    @(posedge clk);
    #1;
    check("rf_we", rf_we, m_we);
    check("rf_rd", rf_rd, m_rd);
    check("rf_wdata", rf_wdata, m_wdata);
    check("sb_err", sb_err, m_err);
  endtask

  task automatic reset_now(input string tag);
    resetn = 0;
    #1;
    model_reset();
    check({tag, "_rf_we"}, rf_we, 1'b0);
    check({tag, "_rf_rd"}, rf_rd, '0);
    check({tag, "_rf_wdata"}, rf_wdata, '0);
    check({tag, "_hazard"}, hazard, 1'b0);
    check({tag, "_sb_err"}, sb_err, 1'b0);
    @(negedge clk);
    resetn = 1;
  endtask

  initial begin
    bit p_hold, l_hold;
    idle();
    model_reset();
    resetn = 1;
    #2;
    chk_rs1 = 5'd3; chk_rs2 = 5'd7;
    reset_now("rst");
    idle();

    // Pipeline write of 0xDEADBEEF to x5, then idle.
    p_valid = 1; p_rd = 5'd5; p_data = 32'hDEADBEEF;
    step();
    check("t1_we", rf_we, 1'b1);
    check("t1_data", rf_wdata, 32'hDEADBEEF);
    idle();
    step();
    check("t1_we_drop", rf_we, 1'b0);

    // Both requesters held: 4 P grants then one forced L grant, repeating.
    p_valid = 1; p_rd = 5'd1; p_data = 32'h1111;
    l_valid = 1; l_rd = 5'd2; l_data = 32'h2222;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("t2_l_ready", l_ready, (i % 5) == 4);
      step();
    end
    idle();
    step();

    // Scoreboard set on x7, L commit clears it.
    sb_set = 1; sb_rd = 5'd7;
    step();
    sb_set = 0; chk_rs1 = 5'd7;
    #1 check("t3_hazard_set", hazard, 1'b1);
    l_valid = 1; l_rd = 5'd7; l_data = 32'hCAFE0007;
    step();
    l_valid = 0;
    step();
    #1 check("t3_hazard_clr", hazard, 1'b0);
    step();

    // x0 requests never write and never hazard.
    idle();
    p_valid = 1; p_rd = 5'd0; p_data = 32'h12345678;
    step();
    check("t4_we_x0", rf_we, 1'b0);
    idle();
    sb_set = 1; sb_rd = 5'd0;
    step();
    sb_set = 0;
    step();
    check("t4_hazard_x0", hazard, 1'b0);

    // Double set on x9 is a sticky error.
    sb_set = 1; sb_rd = 5'd9;
    step();
    step();
    sb_set = 0;
    step();
    check("t5_err_sticky", sb_err, 1'b1);
    reset_now("rst2");
    idle();

    // Set on x9 on the same edge its L write commits: stays pending, no error.
    sb_set = 1; sb_rd = 5'd9;
    step();
    sb_set = 0;
    l_valid = 1; l_rd = 5'd9; l_data = 32'h99;
    step();
    l_valid = 0; sb_set = 1; sb_rd = 5'd9; chk_rs2 = 5'd9;
    step();
    sb_set = 0;
    #1 check("t5_pend9", hazard, 1'b1);
    check("t5_no_err", sb_err, 1'b0);
    step();

    // Async reset mid-cycle with pending x3, rf_we=1 and a part-starved L.
    idle();
    sb_set = 1; sb_rd = 5'd3;
    step();
    sb_set = 0; chk_rs1 = 5'd3;
    p_valid = 1; p_rd = 5'd4; p_data = 32'h44;
    l_valid = 1; l_rd = 5'd6; l_data = 32'h66;
    step();
    step();
    check("t6_pre_we", rf_we, 1'b1);
    check("t6_pre_hz", hazard, 1'b1);
    #2;
    reset_now("t6");
    for (int i = 0; i < 6; i++) step();

    // Random traffic with hold-while-stalled requesters.
    idle();
    p_hold = 0; l_hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (!p_hold) begin
        p_valid = ($urandom_range(0, 3) != 0);
        p_rd = AW'($urandom_range(0, 7)); p_data = $urandom;
      end
      if (!l_hold) begin
        l_valid = ($urandom_range(0, 2) != 0);
        l_rd = AW'($urandom_range(0, 7)); l_data = $urandom;
      end
      sb_set = ($urandom_range(0, 5) == 0);
      sb_rd = AW'($urandom_range(0, 7));
      chk_rs1 = AW'($urandom_range(0, 7));
      chk_rs2 = AW'($urandom_range(0, 7));
      chk_rd = AW'($urandom_range(0, 7));
      step();
      p_hold = p_valid && last_win != 1;
      l_hold = l_valid && last_win != 2;
      if (i == 200) begin
        reset_now("rnd_rst");
        p_hold = 0; l_hold = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
